// File: rtl/hub75e_pkg.sv
// hub75e_pkg: shared FSM state type and default panel geometry for the HUB75E write path
package hub75e_pkg;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, SWAP} state_t;
  localparam int COLS_DEF = 64;
  localparam int ROWS_DEF = 32;
  localparam int COL_W_DEF = $clog2(COLS_DEF);
  localparam int ROW_W_DEF = $clog2(ROWS_DEF);
endpackage

// File: rtl/frame_loader.sv
// frame_loader: packs an RGB888 byte stream into pixels and writes them into a bank-swapped two-channel line RAM
module frame_loader
  import hub75e_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        frame_start_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [15:0] ram_wr_addr_o,
  output logic [23:0] ram_wr_data_o,
  output logic        ram_wr_en_ch0_o,
  output logic        ram_wr_en_ch1_o,
  output logic        rd_bank_o,
  output logic        frame_done_o
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic bank_q, bank_d;
  logic take, last_col, last_px, wr;
  assign take = byte_valid_i && byte_ready_o;
  assign last_col = col_q == CW'(COLS - 1);
  assign last_px = last_col && row_q == RW'(ROWS - 1);
  assign wr = state_q == WRITE;
  assign byte_ready_o = state_q == RECV && !frame_start_i;
  // row MSB selects the panel half; dropping it gives the row within that half
  assign ram_wr_en_ch0_o = wr && !row_q[RW-1];
  assign ram_wr_en_ch1_o = wr && row_q[RW-1];
  assign ram_wr_addr_o = {bank_q, 15'((32'(row_q) & (ROWS / 2 - 1)) * COLS + 32'(col_q))};
  assign ram_wr_data_o = {r_q, g_q, b_q};
  assign rd_bank_o = ~bank_q;
  assign frame_done_o = state_q == SWAP;
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    phase_d = phase_q;
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    bank_d = bank_q;
    if (frame_start_i) begin
      state_d = RECV;
      col_d = '0;
      row_d = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        RECV: if (take) begin
          r_d = phase_q == 2'd0 ? byte_data_i : r_q;
          g_d = phase_q == 2'd1 ? byte_data_i : g_q;
          b_d = phase_q == 2'd2 ? byte_data_i : b_q;
          phase_d = phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1;
          state_d = phase_q == 2'd2 ? WRITE : RECV;
        end
        WRITE: begin
          col_d = col_q + 1'b1;
          row_d = last_col ? row_q + 1'b1 : row_q;
          state_d = last_px ? SWAP : RECV;
          bank_d = last_px ? ~bank_q : bank_q;
        end
        SWAP: state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      phase_q <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      bank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      phase_q <= phase_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      bank_q <= bank_d;
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: randomized self-checking bench for frame_loader against a pixel-level reference model
module tb_frame_loader;
  localparam int COLS = 64, ROWS = 32, NPIX = COLS * ROWS;
  logic clk_i = 0, rst_n_i = 0, frame_start_i = 0, byte_valid_i = 0;
  logic [7:0] byte_data_i = 0;
  logic byte_ready_o, ram_wr_en_ch0_o, ram_wr_en_ch1_o, rd_bank_o, frame_done_o;
  logic [15:0] ram_wr_addr_o;
  logic [23:0] ram_wr_data_o;
  frame_loader #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .frame_start_i(frame_start_i),
    .byte_data_i(byte_data_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .ram_wr_en_ch0_o(ram_wr_en_ch0_o), .ram_wr_en_ch1_o(ram_wr_en_ch1_o),
    .rd_bank_o(rd_bank_o), .frame_done_o(frame_done_o)
  );
  always #5 clk_i = ~clk_i;
  int cmp = 0, bad = 0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // model: pixel-level view of the frame (bytes gathered per pixel, pixel index, bank)
  bit m_recv, m_wr, m_done, m_bank, m_fresh;
  int m_px, frame_no, strobes;
  logic [7:0] q[$];
  logic [23:0] m_data;
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      chk("rst_ready", byte_ready_o, 0);
      chk("rst_en", {ram_wr_en_ch0_o, ram_wr_en_ch1_o}, 0);
      chk("rst_addr", ram_wr_addr_o, 0);
      chk("rst_data", ram_wr_data_o, 0);
      chk("rst_done", frame_done_o, 0);
      chk("rst_rdbank", rd_bank_o, 1);
      {m_recv, m_wr, m_done, m_bank} = '0;
      m_fresh = 1;
      m_px = 0;
      frame_no = 0;
      strobes = 0;
      q.delete();
    end else begin
      int row, col;
      bit nw, nd;
      row = m_px / COLS;
      col = m_px % COLS;
      chk("ready", byte_ready_o, m_recv && !frame_start_i);
      chk("done", frame_done_o, m_done);
      chk("rd_bank", rd_bank_o, !m_bank);
      chk("en_ch0", ram_wr_en_ch0_o, m_wr && row < ROWS / 2);
      chk("en_ch1", ram_wr_en_ch1_o, m_wr && row >= ROWS / 2);
      if (m_wr) begin
        chk("addr", ram_wr_addr_o, {m_bank, 15'((row % (ROWS / 2)) * COLS + col)});
        chk("data", ram_wr_data_o, m_data);
        if (frame_no == 1 && m_px == 0) begin
          chk("pin_first_addr", ram_wr_addr_o, 16'h0000);
          chk("pin_first_data", ram_wr_data_o, 24'h000102);
          chk("pin_first_ch0", ram_wr_en_ch0_o, 1);
        end
        if (frame_no == 1 && m_px == 16 * 64) begin
          chk("pin_r16_ch1", ram_wr_en_ch1_o, 1);
          chk("pin_r16_addr", ram_wr_addr_o, 16'h0000);
        end
        if (frame_no == 1 && m_px == 15 * 64 + 63) begin
          chk("pin_r15_ch0", ram_wr_en_ch0_o, 1);
          chk("pin_r15_addr", ram_wr_addr_o, 16'h03FF);
        end
        if (frame_no == 1 && m_px == NPIX - 1) begin
          chk("pin_last_ch1", ram_wr_en_ch1_o, 1);
          chk("pin_last_addr", ram_wr_addr_o, 16'h03FF);
        end
      end
      if (m_fresh) begin
        chk("idle_addr", ram_wr_addr_o, 0);
        chk("idle_data", ram_wr_data_o, 0);
      end
      if (m_done) chk("strobes_per_frame", strobes, 2048);
      strobes += int'(ram_wr_en_ch0_o) + int'(ram_wr_en_ch1_o);
      nw = 0;
      nd = 0;
      if (frame_start_i) begin
        m_recv = 1;
        q.delete();
        m_px = 0;
        m_fresh = 0;
        frame_no++;
        strobes = 0;
      end else if (m_wr) begin
        if (m_px == NPIX - 1) begin
          m_bank = !m_bank;
          nd = 1;
          m_px = 0;
        end else begin
          m_px++;
          m_recv = 1;
        end
      end else if (m_recv && byte_valid_i) begin
        q.push_back(byte_data_i);
        if (q.size() == 3) begin
          m_data = {q[0], q[1], q[2]};
          q.delete();
          nw = 1;
          m_recv = 0;
        end
      end
      m_wr = nw;
      m_done = nd;
    end
  end
  task automatic pulse_start;
    @(posedge clk_i); #1;
    frame_start_i = 1;
    byte_valid_i = 0;
    @(posedge clk_i); #1;
    frame_start_i = 0;
  endtask
  task automatic feed(int nbytes, bit rnd, bit wait_done);
    int k = 0, t = 0;
    bit seen = 0;
    while (k < nbytes && t < 40000) begin
      byte_valid_i = rnd ? $urandom_range(0, 3) != 0 : 1'b1;
      byte_data_i = rnd ? 8'($urandom) : 8'(k);
      @(negedge clk_i);
      if (byte_valid_i && byte_ready_o) k++;
      @(posedge clk_i); #1;
      t++;
    end
    byte_valid_i = 0;
    while (wait_done && !seen && t < 40000) begin
      @(negedge clk_i);
      seen = frame_done_o;
      t++;
    end
    if (t >= 40000) begin
      cmp++;
      bad++;
      $display("FAIL feed_timeout: got %0d bytes expected %0d", k, nbytes);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1;
    repeat (20) @(posedge clk_i);
    #1;
    pulse_start();
    feed(3 * NPIX, 0, 1);
    @(negedge clk_i) chk("rd_bank_after_f1", rd_bank_o, 0);
    pulse_start();
    feed(3 * NPIX, 1, 1);
    @(negedge clk_i) chk("rd_bank_after_f2", rd_bank_o, 1);
    pulse_start();
    feed(301, 0, 0);
    pulse_start();
    feed(3 * NPIX, 0, 1);
    @(negedge clk_i) chk("rd_bank_after_abort", rd_bank_o, 0);
    pulse_start();
    feed(1000, 1, 0);
    #2 rst_n_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1;
    pulse_start();
    feed(3 * NPIX, 0, 1);
    @(negedge clk_i) chk("rd_bank_after_reset_frame", rd_bank_o, 0);
    repeat (5) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
